// File: rtl/mc_arb_pkg.sv
// Shared types and helpers for the multi-core cache arbiter and its picker.
// Purely declarative, so it adds no latency and has no flow control.
package mc_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, REL} arb_state_e;

    // Width needed to index n items, never narrower than one bit
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mc_cache_arbiter_rr_picker.sv
// Round-robin picker: combinational, zero latency; chooses the first request after 'last'.
// It never stalls: valid drops when no request is present and the caller decides whether to accept idx.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Walk from the farthest offset back to the nearest so the nearest one wins
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IW'((int'(last) + i) % N);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/mc_cache_arbiter.sv
// N-core round-robin front end to one cache port; grant and c_valid one cycle after req, done one cycle after c_ready.
// Cores hold req until done; a stalled cache is aborted after TIMEOUT busy cycles with err, and one idle gap follows every transaction.
module mc_cache_arbiter #(
    parameter int N_CORES = 4,
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_CORES-1:0]          req,
    input  logic [N_CORES-1:0]          rw,
    input  logic [N_CORES*ADDR_W-1:0]   addr,
    input  logic [N_CORES*DATA_W-1:0]   wdata,
    output logic [N_CORES-1:0]          gnt,
    output logic [N_CORES-1:0]          done,
    output logic [N_CORES-1:0]          err,
    output logic [DATA_W-1:0]           rdata,
    output logic                        hit,
    output logic                        c_valid,
    output logic                        c_rw,
    output logic [ADDR_W-1:0]           c_addr,
    output logic [DATA_W-1:0]           c_wdata,
    input  logic                        c_ready,
    input  logic                        c_hit,
    input  logic [DATA_W-1:0]           c_rdata
);

    import mc_arb_pkg::*;

    localparam int                 IW       = idx_w(N_CORES);
    localparam int                 CW       = idx_w(TIMEOUT);
    localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [N_CORES-1:0] ONE      = N_CORES'(1);

    arb_state_e    state;
    logic [IW-1:0] last;
    logic [IW-1:0] idx_q;
    logic [CW-1:0] cnt;
    logic          pick_vld;
    logic [IW-1:0] pick_idx;

    rr_picker #(
        .N  (N_CORES),
        .IW (IW)
    ) u_picker (
        .req   (req),
        .last  (last),
        .valid (pick_vld),
        .idx   (pick_idx)
    );

    // done/err are registered, so they appear in the REL cycle on the bit that held gnt
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last    <= IW'(N_CORES - 1);
            idx_q   <= '0;
            cnt     <= '0;
            gnt     <= '0;
            done    <= '0;
            err     <= '0;
            rdata   <= '0;
            hit     <= 1'b0;
            c_valid <= 1'b0;
            c_rw    <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state   <= BUSY;
                        idx_q   <= pick_idx;
                        gnt     <= ONE << pick_idx;
                        c_valid <= 1'b1;
                        c_rw    <= rw[pick_idx];
                        c_addr  <= addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                        c_wdata <= wdata[int'(pick_idx)*DATA_W +: DATA_W];
                    end
                end
                BUSY: begin
                    cnt <= cnt + 1'b1;
                    // c_ready takes precedence over a coincident timeout
                    if (c_ready || cnt == CNT_LAST) begin
                        state   <= REL;
                        done    <= gnt;
                        err     <= c_ready ? '0 : gnt;
                        hit     <= c_ready & c_hit;
                        gnt     <= '0;
                        c_valid <= 1'b0;
                        last    <= idx_q;
                        if (c_ready && !c_rw) begin
                            rdata <= c_rdata;
                        end
                    end
                end
                REL: begin
                    state <= IDLE;
                    done  <= '0;
                    err   <= '0;
                    cnt   <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/mc_cache_arbiter.md
Name: mc_cache_arbiter

Overview:
- Parametrised N-core front end to the shared cache; successor to the single-requester cache/arbiter pairing.
- Accepts per-core read/write requests and selects one core round-robin.
- Drives a single cache transaction port, returns read data and hit status to the winning core, and aborts stalled transactions with a timeout.
- Sits between the multi_processor instances and the cache in the top level.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 12, cache address width.
- DATA_W, 8, data width.
- TIMEOUT, 16, cycles in BUSY without c_ready before abort (>=2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- req  in  N_CORES  per-core request; held by core until its done pulse.
- rw  in  N_CORES  per-core direction, 1=write, 0=read.
- addr  in  N_CORES*ADDR_W  packed per-core address, core k at [k*ADDR_W +: ADDR_W].
- wdata  in  N_CORES*DATA_W  packed per-core write data.
- gnt  out  N_CORES  one-hot grant, high for the whole transaction.
- done  out  N_CORES  one-cycle completion pulse to the granted core.
- err  out  N_CORES  one-cycle timeout pulse, coincident with done.
- rdata  out  DATA_W  read data, valid in the done cycle, held until the next done.
- hit  out  1  cache hit status, valid in the done cycle.
- c_valid  out  1  transaction valid to cache.
- c_rw  out  1  latched direction.
- c_addr  out  ADDR_W  latched address.
- c_wdata  out  DATA_W  latched write data.
- c_ready  in  1  cache completes the transaction this cycle.
- c_hit  in  1  cache hit, sampled with c_ready.
- c_rdata  in  DATA_W  cache read data, sampled with c_ready.

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer last=N_CORES-1 (so core 0 has first priority), timeout counter 0. Reset mid-transaction aborts it; no done or err is issued.
- IDLE: if any req bit is set, select the first requesting index searching last+1, last+2, ... with wrap modulo N_CORES. Latch idx, rw, addr, wdata. Next cycle: state BUSY.
- BUSY: gnt[idx]=1, c_valid=1, c_rw/c_addr/c_wdata come from the latched values, which are stable for the whole of BUSY. Counter increments each cycle.
  - c_ready=1: done[idx] pulse, rdata<=c_rdata (reads only; writes leave rdata unchanged), hit<=c_hit, last<=idx, state REL.
  - Counter reaches TIMEOUT-1 with c_ready=0: done[idx] and err[idx] pulse, hit=0, rdata unchanged, last<=idx, state REL.
  - c_ready and timeout in the same cycle: c_ready wins and err stays 0.
- REL: gnt=0, c_valid=0, counter cleared. State IDLE next cycle. This guarantees one idle cycle between transactions.
- Latency: req seen in IDLE at edge n gives gnt and c_valid from edge n+1. Minimum transaction is 3 cycles (IDLE, BUSY with c_ready, REL).
- Deasserting req during BUSY is ignored; the transaction completes normally.
- Requests on non-granted cores are ignored until IDLE. No starvation: any held request is granted within N_CORES transactions.
- gnt is always one-hot or zero. done and err are only ever asserted on the bit equal to gnt.

Decomposition:
- Package mc_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, REL} arb_state_e;
  - function for index width, $clog2(N_CORES) with minimum 1.
- Sub-module rr_picker: combinational, takes req and last, outputs valid and idx. It is reused by future bus arbiters.

Test Plan:
- Single read: core 2 req, rw=0, addr=12'h3A5; cache returns c_ready on the 2nd BUSY cycle with c_rdata=8'h5C, c_hit=1 -> gnt=4'b0100 for 2 cycles, c_addr=12'h3A5, done[2] pulse, rdata=8'h5C, hit=1.
- Round-robin: all four cores request continuously, cache ready in 1 cycle -> grant order 0,1,2,3,0, with a gnt=0 cycle between each grant.
- Write: core 1 rw=1, addr=12'h010, wdata=8'hA7 -> c_rw=1, c_wdata=8'hA7; after completion rdata keeps its previous value 8'h5C.
- Timeout: core 3 read, c_ready held 0 -> exactly 16 BUSY cycles, then done[3]=err[3]=1 for one cycle, hit=0; next grant goes to core 0.
- Simultaneous: c_ready asserted on the 16th BUSY cycle -> done=1, err=0, data captured.
- Reset mid-transaction: rst=0 during BUSY of core 1 -> gnt, c_valid and done go to 0 immediately; after release with core 1 and core 3 requesting, core 1 is granted first (pointer reset).
